// File: rtl/cascade_master_sequencer.sv
// -----------------------------------------------------------------------------
// cascade_master_sequencer
//
// Master-side sequencer for a cascaded interrupt controller. It follows the
// two-pulse interrupt-acknowledge handshake on i_inta_n. On the first pulse it
// decides whether the acknowledged IR line has a slave attached. If it does,
// the sequencer drives that slave's address onto the cascade bus. If it does
// not, the master supplies the vector itself during the second pulse. A
// watchdog abandons the sequence when the second pulse does not start within
// TIMEOUT_CYCLES of the end of the first one.
//
// Ports
//   i_clk          single clock, all state changes on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_spen         1 = master mode (block active), 0 = slave mode (inert)
//   i_inta_n       interrupt-acknowledge strobe, active-low, synchronous
//   i_icw3_slaves  bit i set = slave attached on IR line i
//   i_ack_ir_id    IR being acknowledged, sampled on the first INTA fall only
//   o_cascade      slave address on the cascade bus (3'b000 when not driven)
//   o_cas_oe       cascade bus drive enable for the external tristate
//   o_vector_en    master supplies the vector during the second pulse
//   o_cycle_done   one-cycle pulse on normal completion of the second pulse
//   o_timeout_err  one-cycle pulse when the inter-pulse gap times out
// -----------------------------------------------------------------------------
module cascade_master_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_spen,
    input  logic       i_inta_n,
    input  logic [7:0] i_icw3_slaves,
    input  logic [2:0] i_ack_ir_id,
    output logic [2:0] o_cascade,
    output logic       o_cas_oe,
    output logic       o_vector_en,
    output logic       o_cycle_done,
    output logic       o_timeout_err
);

    // The counter only has to hold values up to TIMEOUT_CYCLES, so it can
    // never wrap before the timeout fires.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The timeout fires on the GAP edge that would take the count to
    // TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_GAP  = 2'd2,
        ST_P2   = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_inta_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_casc;
    logic [2:0]       r_cascade;
    logic             r_cas_oe;
    logic             r_vector_en;
    logic             r_cycle_done;
    logic             r_timeout_err;

    logic w_fall;
    logic w_rise;
    logic w_casc;

    assign w_fall = r_inta_prev & ~i_inta_n;
    assign w_rise = ~r_inta_prev & i_inta_n;
    assign w_casc = i_icw3_slaves[i_ack_ir_id];

    // Handshake FSM with INTA edge history, gap watchdog and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_inta_prev   <= 1'b1;
            r_cnt         <= '0;
            r_casc        <= 1'b0;
            r_cascade     <= 3'b000;
            r_cas_oe      <= 1'b0;
            r_vector_en   <= 1'b0;
            r_cycle_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_inta_prev   <= i_inta_n;
            r_cycle_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            if ((r_state != ST_IDLE) && !i_spen) begin
                // Leaving master mode drops the sequence silently.
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_cascade   <= 3'b000;
                r_cas_oe    <= 1'b0;
                r_vector_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_fall && i_spen) begin
                            // The IR number and its cascade status are frozen
                            // here and held for the entire handshake.
                            r_state   <= ST_P1;
                            r_cnt     <= '0;
                            r_casc    <= w_casc;
                            r_cas_oe  <= w_casc;
                            r_cascade <= w_casc ? i_ack_ir_id : 3'b000;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_P1: begin
                        if (w_rise) begin
                            r_state <= ST_GAP;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_P1;
                        end
                    end
                    ST_GAP: begin
                        // A fall on the timeout edge still counts as on time.
                        if (w_fall) begin
                            r_state     <= ST_P2;
                            r_cnt       <= '0;
                            r_vector_en <= ~r_casc;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state       <= ST_IDLE;
                            r_cnt         <= '0;
                            r_timeout_err <= 1'b1;
                            r_cascade     <= 3'b000;
                            r_cas_oe      <= 1'b0;
                            r_vector_en   <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_P2: begin
                        if (w_rise) begin
                            r_state      <= ST_IDLE;
                            r_cycle_done <= 1'b1;
                            r_cascade    <= 3'b000;
                            r_cas_oe     <= 1'b0;
                            r_vector_en  <= 1'b0;
                        end else begin
                            r_state <= ST_P2;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_cascade   <= 3'b000;
                        r_cas_oe    <= 1'b0;
                        r_vector_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cascade     = r_cascade;
    assign o_cas_oe      = r_cas_oe;
    assign o_vector_en   = r_vector_en;
    assign o_cycle_done  = r_cycle_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cascade_master_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cascade_master_sequencer. A transaction-level model tracks the
// acknowledge handshake as "which pulse, low or high, how long in the gap" and
// is compared with the DUT every cycle. Directed scenarios add hand-computed
// cycle counts that pin the model.
// -----------------------------------------------------------------------------
module tb_cascade_master_sequencer;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spen;
    logic       inta_n;
    logic [7:0] slaves;
    logic [2:0] ack;
    logic [2:0] o_cascade;
    logic       o_cas_oe;
    logic       o_vector_en;
    logic       o_cycle_done;
    logic       o_timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int c_oe, c_ven, c_done, c_to;

    cascade_master_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_spen        (spen),
        .i_inta_n      (inta_n),
        .i_icw3_slaves (slaves),
        .i_ack_ir_id   (ack),
        .o_cascade     (o_cascade),
        .o_cas_oe      (o_cas_oe),
        .o_vector_en   (o_vector_en),
        .o_cycle_done  (o_cycle_done),
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_prev, m_active, m_low, m_casc;
    int         m_pulse, m_gap;
    logic [2:0] m_id;
    logic [2:0] e_cas;
    bit         e_oe, e_ven, e_done, e_to;

    task automatic model_drop();
        m_active = 1'b0;
        e_cas    = 3'd0;
        e_oe     = 1'b0;
        e_ven    = 1'b0;
    endtask

    initial begin
        bit fall, rise;
        forever begin
            @(posedge clk);
            e_done = 1'b0;
            e_to   = 1'b0;
            if (!rst_n) begin
                m_prev = 1'b1;
                model_drop();
            end else begin
                fall   = m_prev && !inta_n;
                rise   = !m_prev && inta_n;
                m_prev = inta_n;
                if (!m_active) begin
                    if (fall && spen) begin
                        m_active = 1'b1;
                        m_pulse  = 1;
                        m_low    = 1'b1;
                        m_id     = ack;
                        m_casc   = slaves[ack];
                        e_oe     = m_casc;
                        e_cas    = m_casc ? m_id : 3'd0;
                    end
                end else if (!spen) begin
                    model_drop();
                end else if (m_low) begin
                    if (rise) begin
                        if (m_pulse == 1) begin
                            m_low = 1'b0;
                            m_gap = 0;
                        end else begin
                            e_done = 1'b1;
                            model_drop();
                        end
                    end
                end else if (fall) begin
                    m_low   = 1'b1;
                    m_pulse = 2;
                    e_ven   = !m_casc;
                end else begin
                    m_gap++;
                    if (m_gap == T) begin
                        e_to = 1'b1;
                        model_drop();
                    end
                end
            end
            #1;
            check("cascade", {29'd0, o_cascade}, {29'd0, e_cas});
            check("cas_oe", {31'd0, o_cas_oe}, {31'd0, e_oe});
            check("vector_en", {31'd0, o_vector_en}, {31'd0, e_ven});
            check("cycle_done", {31'd0, o_cycle_done}, {31'd0, e_done});
            check("timeout_err", {31'd0, o_timeout_err}, {31'd0, e_to});
            check("oe_ven_excl", {31'd0, o_cas_oe & o_vector_en}, 32'd0);
            if (o_cas_oe)      c_oe++;
            if (o_vector_en)   c_ven++;
            if (o_cycle_done)  c_done++;
            if (o_timeout_err) c_to++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_counts();
        c_oe = 0; c_ven = 0; c_done = 0; c_to = 0;
    endtask

    task automatic pulse_pair(input int low1, input int gap, input int low2,
                              input bit chg_id, input logic [2:0] new_id);
        inta_n = 1'b0;
        repeat (low1) @(negedge clk);
        inta_n = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            if (chg_id) ack = new_id;
        end
        inta_n = 1'b0;
        repeat (low2) @(negedge clk);
        if (chg_id) check("cascade_held_p2", {29'd0, o_cascade}, 32'd5);
        inta_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int oe, input int ven,
                                input int done, input int to);
        check({tag, "_oe_cycles"}, c_oe, oe);
        check({tag, "_ven_cycles"}, c_ven, ven);
        check({tag, "_done_pulses"}, c_done, done);
        check({tag, "_timeout_pulses"}, c_to, to);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        rst_n  = 1'b0;
        spen   = 1'b1;
        inta_n = 1'b1;
        slaves = 8'h24;
        ack    = 3'd5;
        clear_counts();
        #3;
        check("reset_outputs", {27'd0, o_cascade, o_cas_oe, o_vector_en, o_cycle_done, o_timeout_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // cascaded IR5: bus driven for all 10 cycles of the handshake
        clear_counts();
        pulse_pair(3, 4, 3, 1'b0, 3'd0);
        check_counts("casc_ir5", 10, 0, 1, 0);

        // non-cascaded IR3: master vector for the 3 cycles of pulse two
        ack = 3'd3;
        clear_counts();
        pulse_pair(3, 4, 3, 1'b0, 3'd0);
        check_counts("local_ir3", 0, 3, 1, 0);

        // ACK_IR_ID changes during the gap and is ignored
        ack = 3'd5;
        clear_counts();
        pulse_pair(3, 4, 3, 1'b1, 3'd2);
        check_counts("id_change", 10, 0, 1, 0);
        ack = 3'd5;

        // second fall lands on the timeout edge: fall wins
        clear_counts();
        pulse_pair(3, T, 3, 1'b0, 3'd0);
        check_counts("gap_boundary", 14, 0, 1, 0);

        // timeout: first pulse only
        clear_counts();
        inta_n = 1'b0;
        repeat (3) @(negedge clk);
        inta_n = 1'b1;
        @(negedge clk);
        k = 0;
        while (!o_timeout_err && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", k, T);
        @(negedge clk);
        check("cas_oe_after_timeout", {31'd0, o_cas_oe}, 32'd0);
        check_counts("timeout", 11, 0, 0, 1);
        clear_counts();
        pulse_pair(3, 4, 3, 1'b0, 3'd0);
        check_counts("after_timeout", 10, 0, 1, 0);

        // slave mode: block inert
        spen = 1'b0;
        clear_counts();
        pulse_pair(3, 4, 3, 1'b0, 3'd0);
        check_counts("slave_mode", 0, 0, 0, 0);
        spen = 1'b1;
        @(negedge clk);

        // SPEN dropped in the gap: outputs clear, no pulses ever follow
        clear_counts();
        inta_n = 1'b0;
        repeat (3) @(negedge clk);
        inta_n = 1'b1;
        repeat (2) @(negedge clk);
        spen = 1'b0;
        @(negedge clk);
        check("cas_oe_after_spen_drop", {31'd0, o_cas_oe}, 32'd0);
        spen = 1'b1;
        repeat (12) @(negedge clk);
        check_counts("spen_drop", 5, 0, 0, 0);

        // asynchronous reset in the gap with the bus driven
        inta_n = 1'b0;
        repeat (3) @(negedge clk);
        inta_n = 1'b1;
        repeat (2) @(negedge clk);
        check("cas_oe_in_gap", {31'd0, o_cas_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clear", {27'd0, o_cascade, o_cas_oe, o_vector_en, o_cycle_done, o_timeout_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_counts();
        pulse_pair(3, 4, 3, 1'b0, 3'd0);
        check_counts("after_reset", 10, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
